// File: rtl/eth_phy_10g_tx_seq.sv
// XGMII TX sequencer: startup idles, MAC pass-through, fault ordered sets, PRBS31 test.
// Optional TX_SEQ_STATS_EN adds saturating frame-cut and fault-entry counters.
module eth_phy_10g_tx_seq #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = 8,
  parameter int STARTUP_IDLE    = 16,
  parameter int FAULT_QUAL      = 4,
  parameter int MAX_FRAME_WORDS = 1200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mac_txd,
  input  logic [CTRL_WIDTH-1:0] mac_txc,
  input  logic                  rx_local_fault,
  input  logic                  rx_remote_fault,
  input  logic                  test_req,
  output logic [DATA_WIDTH-1:0] xgmii_txd,
  output logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic                  cfg_tx_prbs31_enable,
  output logic [2:0]            seq_state,
`ifdef TX_SEQ_STATS_EN
  output logic [15:0]           stat_cut_cnt,
  output logic [15:0]           stat_fault_cnt,
`endif
  output logic                  frame_cut
);

  localparam int CW = 16;
  localparam int QW = 8;
  localparam logic [DATA_WIDTH-1:0] IDLE_W = {CTRL_WIDTH{8'h07}};
  localparam logic [DATA_WIDTH-1:0] ERR_W  = {CTRL_WIDTH{8'hFE}};
  localparam logic [DATA_WIDTH-1:0] RF_W   = {(DATA_WIDTH/32){32'h0200009C}};
  localparam logic [CTRL_WIDTH-1:0] RF_C   = {(CTRL_WIDTH/4){4'h1}};

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_PASS    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_FAULT   = 3'd3,
    ST_TEST    = 3'd4
  } state_t;

  state_t                state_q, state_d, tgt;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [QW-1:0]         lf_cnt_q, lf_cnt_d, rf_cnt_q, rf_cnt_d;
  logic                  lf_q, lf_d, rf_q, rf_d;
  logic                  in_frame_q, in_frame_d, nf, has_tgt;
  logic                  test_q;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic [CTRL_WIDTH-1:0] txc_q, txc_d;
  logic                  prbs_q, prbs_d, cut_q, cut_d;

  // Later lanes override earlier ones, so a word with both START and TERMINATE resolves by lane order.
  function automatic logic frame_next(input logic                  cur,
                                      input logic [DATA_WIDTH-1:0] d,
                                      input logic [CTRL_WIDTH-1:0] c);
    logic f;
    f = cur;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (c[i] && d[8*i+:8] == 8'hFD) f = 1'b0;
      else if (c[i] && d[8*i+:8] == 8'hFB && (i == 0 || i == 4)) f = 1'b1;
    end
    return f;
  endfunction

  always_comb begin
    lf_d     = lf_q;
    lf_cnt_d = '0;
    if (rx_local_fault != lf_q) begin
      if (lf_cnt_q == QW'(FAULT_QUAL - 1)) lf_d = rx_local_fault;
      else lf_cnt_d = lf_cnt_q + QW'(1);
    end
    rf_d     = rf_q;
    rf_cnt_d = '0;
    if (rx_remote_fault != rf_q) begin
      if (rf_cnt_q == QW'(FAULT_QUAL - 1)) rf_d = rx_remote_fault;
      else rf_cnt_d = rf_cnt_q + QW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_frame_d = in_frame_q;
    txd_d      = IDLE_W;
    txc_d      = '1;
    cut_d      = 1'b0;
    has_tgt    = test_req | lf_q | rf_q;
    nf         = frame_next(in_frame_q, mac_txd, mac_txc);
    if (test_req)         tgt = ST_TEST;
    else if (lf_q | rf_q) tgt = ST_FAULT;
    else                  tgt = ST_PASS;
    unique case (state_q)
      ST_STARTUP: begin
        in_frame_d = 1'b0;
        if (test_req && !test_q) cnt_d = '0;
        else if (cnt_q == CW'(STARTUP_IDLE - 1)) state_d = tgt;
        else cnt_d = cnt_q + CW'(1);
      end
      ST_PASS: begin
        txd_d      = mac_txd;
        txc_d      = mac_txc;
        in_frame_d = nf;
        if (has_tgt) state_d = nf ? ST_DRAIN : tgt;
      end
      ST_DRAIN: begin
        txd_d      = mac_txd;
        txc_d      = mac_txc;
        in_frame_d = nf;
        if (!has_tgt) state_d = ST_PASS;
        else if (!nf) state_d = tgt;
        else if (cnt_q == CW'(MAX_FRAME_WORDS - 1)) begin
          txd_d      = ERR_W;
          txc_d      = '1;
          cut_d      = 1'b1;
          in_frame_d = 1'b0;
          state_d    = tgt;
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_FAULT: begin
        in_frame_d = 1'b0;
        if (test_req) state_d = ST_TEST;
        else if (!lf_q && !rf_q) state_d = ST_STARTUP;
        else if (lf_q) begin
          txd_d = RF_W;
          txc_d = RF_C;
        end
      end
      ST_TEST: begin
        in_frame_d = 1'b0;
        if (!test_req) state_d = ST_STARTUP;
      end
      default: state_d = ST_STARTUP;
    endcase
    // Every state entry starts its word count from zero.
    if (state_d != state_q) cnt_d = '0;
    prbs_d = (state_d == ST_TEST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STARTUP;
      cnt_q      <= '0;
      lf_q       <= 1'b0;
      rf_q       <= 1'b0;
      lf_cnt_q   <= '0;
      rf_cnt_q   <= '0;
      in_frame_q <= 1'b0;
      test_q     <= 1'b0;
      txd_q      <= IDLE_W;
      txc_q      <= '1;
      prbs_q     <= 1'b0;
      cut_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lf_q       <= lf_d;
      rf_q       <= rf_d;
      lf_cnt_q   <= lf_cnt_d;
      rf_cnt_q   <= rf_cnt_d;
      in_frame_q <= in_frame_d;
      test_q     <= test_req;
      txd_q      <= txd_d;
      txc_q      <= txc_d;
      prbs_q     <= prbs_d;
      cut_q      <= cut_d;
    end
  end

`ifdef TX_SEQ_STATS_EN
  logic [15:0] cut_cnt_q, fault_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cut_cnt_q   <= '0;
      fault_cnt_q <= '0;
    end else begin
      if (cut_d && cut_cnt_q != 16'hFFFF) cut_cnt_q <= cut_cnt_q + 16'd1;
      if (state_d == ST_FAULT && state_q != ST_FAULT && fault_cnt_q != 16'hFFFF)
        fault_cnt_q <= fault_cnt_q + 16'd1;
    end
  end

  assign stat_cut_cnt   = cut_cnt_q;
  assign stat_fault_cnt = fault_cnt_q;
`endif

  assign xgmii_txd            = txd_q;
  assign xgmii_txc            = txc_q;
  assign cfg_tx_prbs31_enable = prbs_q;
  assign seq_state            = state_q;
  assign frame_cut            = cut_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_seq.sv
// Directed bench for eth_phy_10g_tx_seq: vector table plus hand-written
// frame drain, frame cut and mid-frame reset sequences.
module tb_eth_phy_10g_tx_seq;

  localparam logic [63:0] I  = 64'h0707070707070707;
  localparam logic [63:0] RF = 64'h0200009C0200009C;
  localparam logic [63:0] ER = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] JK = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] W1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] SF = 64'hD5555555555555FB;
  localparam logic [63:0] TM = 64'h07070707070707FD;

  logic        clk, rst;
  logic [63:0] mac_txd, xgmii_txd;
  logic [7:0]  mac_txc, xgmii_txc;
  logic        rx_local_fault, rx_remote_fault, test_req;
  logic        cfg_tx_prbs31_enable, frame_cut;
  logic [2:0]  seq_state;

  int tests = 0;
  int fails = 0;

  eth_phy_10g_tx_seq #(.MAX_FRAME_WORDS(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mac_txd              (mac_txd),
    .mac_txc              (mac_txc),
    .rx_local_fault       (rx_local_fault),
    .rx_remote_fault      (rx_remote_fault),
    .test_req             (test_req),
    .xgmii_txd            (xgmii_txd),
    .xgmii_txc            (xgmii_txc),
    .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable),
    .seq_state            (seq_state),
    .frame_cut            (frame_cut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        lf, rf, tr;
    logic [63:0] etxd;
    logic [7:0]  etxc;
    logic [2:0]  est;
    logic        eprbs, ecut;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic r, input logic [63:0] d, input logic [7:0] c,
                   input logic lf, input logic rf, input logic tr,
                   input logic [63:0] ed, input logic [7:0] ec,
                   input logic [2:0] es, input logic ep, input logic ect);
    vec_t e;
    e.rst = r; e.txd = d; e.txc = c; e.lf = lf; e.rf = rf; e.tr = tr;
    e.etxd = ed; e.etxc = ec; e.est = es; e.eprbs = ep; e.ecut = ect;
    vq.push_back(e);
  endtask

  // 16 startup words with junk MAC data, landing in state tgt
  task automatic startup_v(input logic lf, input logic [2:0] tgt);
    for (int i = 0; i < 15; i++) v(0, JK, 8'h00, lf, 0, 0, I, 8'hFF, 3'd0, 0, 0);
    v(0, JK, 8'h00, lf, 0, 0, I, 8'hFF, tgt, 0, 0);
  endtask

  task automatic apply(input logic r, input logic [63:0] d, input logic [7:0] c,
                       input logic lf, input logic rf, input logic tr);
    rst = r; mac_txd = d; mac_txc = c;
    rx_local_fault = lf; rx_remote_fault = rf; test_req = tr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] ed, input logic [7:0] ec,
                     input logic [2:0] es, input logic ep, input logic ect);
    tests++;
    if (xgmii_txd !== ed || xgmii_txc !== ec || seq_state !== es ||
        cfg_tx_prbs31_enable !== ep || frame_cut !== ect) begin
      fails++;
      $display("FAIL %s: got txd=%h txc=%h st=%0d prbs=%b cut=%b, want txd=%h txc=%h st=%0d prbs=%b cut=%b",
               nm, xgmii_txd, xgmii_txc, seq_state, cfg_tx_prbs31_enable, frame_cut,
               ed, ec, es, ep, ect);
    end
  endtask

  task automatic recover();
    for (int i = 0; i < 5; i++) apply(0, I, 8'hFF, 0, 0, 0);
    chk("recover_startup", I, 8'hFF, 3'd0, 0, 0);
    for (int i = 0; i < 15; i++) apply(0, I, 8'hFF, 0, 0, 0);
    chk("recover_still_startup", I, 8'hFF, 3'd0, 0, 0);
    apply(0, I, 8'hFF, 0, 0, 0);
    chk("recover_pass", I, 8'hFF, 3'd1, 0, 0);
  endtask

  logic [63:0] pw[6];
  logic [7:0]  pc[6];
  logic [63:0] dw;

  initial begin
    rst = 1'b1; mac_txd = I; mac_txc = 8'hFF;
    rx_local_fault = 0; rx_remote_fault = 0; test_req = 0;

    pw[0] = W1;                    pc[0] = 8'h00;
    pw[1] = I;                     pc[1] = 8'hFF;
    pw[2] = SF;                    pc[2] = 8'h01;
    pw[3] = 64'hA5A5A5A55A5A5A5A;  pc[3] = 8'h00;
    pw[4] = 64'h070707FD12345678;  pc[4] = 8'hF0;
    pw[5] = I;                     pc[5] = 8'hFF;

    // reset, startup, pass-through
    v(1, I, 8'hFF, 0, 0, 0, I, 8'hFF, 3'd0, 0, 0);
    startup_v(0, 3'd1);
    for (int i = 0; i < 6; i++) v(0, pw[i], pc[i], 0, 0, 0, pw[i], pc[i], 3'd1, 0, 0);
    // local fault: 3-cycle glitch ignored, 4-cycle hold qualifies
    for (int i = 0; i < 3; i++) v(0, I, 8'hFF, 1, 0, 0, I, 8'hFF, 3'd1, 0, 0);
    v(0, I, 8'hFF, 0, 0, 0, I, 8'hFF, 3'd1, 0, 0);
    for (int i = 0; i < 4; i++) v(0, I, 8'hFF, 1, 0, 0, I, 8'hFF, 3'd1, 0, 0);
    v(0, W1, 8'h00, 1, 0, 0, W1, 8'h00, 3'd3, 0, 0);
    v(0, I, 8'hFF, 1, 0, 0, RF, 8'h11, 3'd3, 0, 0);
    for (int i = 0; i < 4; i++) v(0, I, 8'hFF, 0, 0, 0, RF, 8'h11, 3'd3, 0, 0);
    v(0, I, 8'hFF, 0, 0, 0, I, 8'hFF, 3'd0, 0, 0);
    startup_v(0, 3'd1);
    // remote fault only: FAULT sends idle
    for (int i = 0; i < 4; i++) v(0, I, 8'hFF, 0, 1, 0, I, 8'hFF, 3'd1, 0, 0);
    v(0, W1, 8'h00, 0, 1, 0, W1, 8'h00, 3'd3, 0, 0);
    for (int i = 0; i < 2; i++) v(0, I, 8'hFF, 0, 1, 0, I, 8'hFF, 3'd3, 0, 0);
    for (int i = 0; i < 4; i++) v(0, I, 8'hFF, 0, 0, 0, I, 8'hFF, 3'd3, 0, 0);
    v(0, I, 8'hFF, 0, 0, 0, I, 8'hFF, 3'd0, 0, 0);
    startup_v(0, 3'd1);
    // test request overrides local fault
    for (int i = 0; i < 4; i++) v(0, I, 8'hFF, 1, 0, 0, I, 8'hFF, 3'd1, 0, 0);
    v(0, I, 8'hFF, 1, 0, 0, I, 8'hFF, 3'd3, 0, 0);
    v(0, I, 8'hFF, 1, 0, 1, I, 8'hFF, 3'd4, 1, 0);
    v(0, I, 8'hFF, 1, 0, 1, I, 8'hFF, 3'd4, 1, 0);
    v(0, I, 8'hFF, 1, 0, 0, I, 8'hFF, 3'd0, 0, 0);
    startup_v(1, 3'd3);
    v(0, I, 8'hFF, 1, 0, 0, RF, 8'h11, 3'd3, 0, 0);
    for (int i = 0; i < 4; i++) v(0, I, 8'hFF, 0, 0, 0, RF, 8'h11, 3'd3, 0, 0);
    v(0, I, 8'hFF, 0, 0, 0, I, 8'hFF, 3'd0, 0, 0);
    startup_v(0, 3'd1);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].rst, vq[i].txd, vq[i].txc, vq[i].lf, vq[i].rf, vq[i].tr);
      chk($sformatf("vec%0d", i), vq[i].etxd, vq[i].etxc, vq[i].est, vq[i].eprbs, vq[i].ecut);
    end

    // fault raised mid-frame: frame drains intact through terminate
    apply(0, SF, 8'h01, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      dw = {32'hDA7A0000, 32'(i)};
      apply(0, dw, 8'h00, i >= 12, 0, 0);
      if (i == 15) chk("drain_pre", dw, 8'h00, 3'd1, 0, 0);
      if (i == 16) chk("drain_enter", dw, 8'h00, 3'd2, 0, 0);
    end
    apply(0, TM, 8'hFF, 1, 0, 0);
    chk("drain_term", TM, 8'hFF, 3'd3, 0, 0);
    apply(0, I, 8'hFF, 1, 0, 0);
    chk("drain_rf", RF, 8'h11, 3'd3, 0, 0);
    recover();

    // frame without terminate: 8th drain word cut
    apply(0, SF, 8'h01, 1, 0, 0);
    for (int i = 1; i <= 4; i++) apply(0, {32'hC0DE0000, 32'(i)}, 8'h00, 1, 0, 0);
    chk("cut_enter", {32'hC0DE0000, 32'd4}, 8'h00, 3'd2, 0, 0);
    for (int k = 1; k <= 7; k++) apply(0, {32'hC0DE0100, 32'(k)}, 8'h00, 1, 0, 0);
    chk("cut_before", {32'hC0DE0100, 32'd7}, 8'h00, 3'd2, 0, 0);
    apply(0, {32'hC0DE0100, 32'd8}, 8'h00, 1, 0, 0);
    chk("cut_word", ER, 8'hFF, 3'd3, 0, 1);
    apply(0, I, 8'hFF, 1, 0, 0);
    chk("cut_after", RF, 8'h11, 3'd3, 0, 0);
    recover();

    // reset while draining
    apply(0, SF, 8'h01, 1, 0, 0);
    for (int i = 1; i <= 4; i++) apply(0, {32'hBEEF0000, 32'(i)}, 8'h00, 1, 0, 0);
    chk("rst_drain_enter", {32'hBEEF0000, 32'd4}, 8'h00, 3'd2, 0, 0);
    apply(0, {32'hBEEF0000, 32'd5}, 8'h00, 1, 0, 0);
    apply(1, {32'hBEEF0000, 32'd6}, 8'h00, 1, 0, 0);
    chk("rst_mid", I, 8'hFF, 3'd0, 0, 0);
    for (int i = 0; i < 15; i++) apply(0, I, 8'hFF, 0, 0, 0);
    chk("rst_startup", I, 8'hFF, 3'd0, 0, 0);
    apply(0, I, 8'hFF, 0, 0, 0);
    chk("rst_pass", I, 8'hFF, 3'd1, 0, 0);
    apply(0, W1, 8'h00, 0, 0, 0);
    chk("rst_fwd", W1, 8'h00, 3'd1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
